// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO among NUM_REQ requesters, with
// locked multi-operation sequences and a one-cycle registered response stage.
module lifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_op_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  output logic                          resp_err_o,
  output logic                          lifo_push_o,
  output logic [DATA_WIDTH-1:0]         lifo_push_data_o,
  output logic                          lifo_pop_o,
  input  logic [DATA_WIDTH-1:0]         lifo_pop_data_i,
  input  logic                          lifo_empty_i,
  input  logic                          lifo_full_i,
  output logic [IDX_W-1:0]              owner_o,
  output logic                          locked_o
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [CNT_W-1:0]       lock_cnt_q;

  logic [DATA_WIDTH-1:0]  req_data_a [NUM_REQ];
  int                     scan_idx;
  logic                   win_vld_p0;
  logic [IDX_W-1:0]       win_idx_p0;
  logic                   win_op_p0;
  logic                   win_lock_p0;
  logic                   push_ok_p0;
  logic                   pop_ok_p0;
  logic                   op_err_p0;

  logic [NUM_REQ-1:0]     vld_p1;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   err_p1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_a[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage p0: winner selection and LIFO strobes, all in the grant cycle.
  // Scanning offsets from high to low lets the nearest requester overwrite.
  always_comb begin
    win_vld_p0 = 1'b0;
    win_idx_p0 = '0;
    scan_idx   = 0;
    if (reset_ni) begin
      if (state_q == ST_LOCKED) begin
        win_idx_p0 = owner_q;
        win_vld_p0 = req_valid_i[owner_q];
      end else begin
        for (int k = NUM_REQ; k >= 1; k--) begin
          scan_idx = int'(last_grant_q) + k;
          if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
          if (req_valid_i[IDX_W'(scan_idx)]) begin
            win_vld_p0 = 1'b1;
            win_idx_p0 = IDX_W'(scan_idx);
          end
        end
      end
    end
  end

  assign win_op_p0   = req_op_i[win_idx_p0];
  assign win_lock_p0 = req_lock_i[win_idx_p0];
  assign push_ok_p0  = win_vld_p0 & ~win_op_p0 & ~lifo_full_i;
  assign pop_ok_p0   = win_vld_p0 &  win_op_p0 & ~lifo_empty_i;
  assign op_err_p0   = win_vld_p0 & ~push_ok_p0 & ~pop_ok_p0;

  assign req_ready_o      = win_vld_p0 ? (NUM_REQ'(1) << win_idx_p0) : '0;
  assign lifo_push_o      = push_ok_p0;
  assign lifo_pop_o       = pop_ok_p0;
  assign lifo_push_data_o = push_ok_p0 ? req_data_a[win_idx_p0] : '0;

  // Stage p1: registered completion; pop data is sampled before the LIFO moves.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_p1  <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= req_ready_o;
      data_p1 <= pop_ok_p0 ? lifo_pop_data_i : '0;
      err_p1  <= op_err_p0;
    end
  end

  assign resp_valid_o = vld_p1;
  assign resp_data_o  = data_p1;
  assign resp_err_o   = err_p1;

  // Grant bookkeeping; a release hands priority to the requester after the owner.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_ARB;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      lock_cnt_q   <= '0;
    end else if (win_vld_p0) begin
      case (state_q)
        ST_ARB: begin
          last_grant_q <= win_idx_p0;
          if (win_lock_p0 && (MAX_LOCK > 1)) begin
            state_q    <= ST_LOCKED;
            owner_q    <= win_idx_p0;
            lock_cnt_q <= CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (win_lock_p0 && (lock_cnt_q != CNT_W'(MAX_LOCK - 1))) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            state_q      <= ST_ARB;
            last_grant_q <= owner_q;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign locked_o = (state_q == ST_LOCKED);
  assign owner_o  = owner_q;

endmodule
